// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the instruction-fetch path: fetch FSM state
// encoding, default datapath width and instruction-memory depth, and a
// helper that yields the last valid byte address of the instruction memory.
package mips_pkg;

   localparam int LARGURA_PADRAO      = 16;
   localparam int PALAVRAS_ROM_PADRAO = 64;

   typedef enum logic [1:0] {
      INICIO = 2'd0,
      BUSCA  = 2'd1,
      PARADO = 2'd2,
      ERRO   = 2'd3
   } estado_t;

   // Highest byte address that still holds a full 16-bit word.
   function automatic int ultimo_endereco(input int palavras);
      return 2 * palavras - 2;
   endfunction

endpackage

// File: rtl/controle_busca_verifica_endereco.sv
// verifica_endereco
// Purely combinational check of a byte address against the instruction
// memory: it must be word aligned and not beyond the last word.
// Ports:
//   endereco  in  LARGURA  byte address to check
//   valido    out 1        1 when aligned and inside the memory
module verifica_endereco
   import mips_pkg::*;
#(
   parameter int LARGURA      = LARGURA_PADRAO,
   parameter int PALAVRAS_ROM = PALAVRAS_ROM_PADRAO
) (
   input  logic [LARGURA-1:0] endereco,
   output logic               valido
);

   localparam logic [LARGURA-1:0] LIMITE = LARGURA'(ultimo_endereco(PALAVRAS_ROM));

   assign valido = ~endereco[0] & (endereco <= LIMITE);

endmodule

// File: rtl/controle_busca.sv
// controle_busca
// Instruction fetch controller. Drives pc to an external combinational
// instruction memory, registers the returned word into ir and offers it to
// decode with a valid/ready handshake; handles redirects, halt/resume and
// fetch faults.
//
// Handshake: ir/pc_ir are offered while ir_valido=1; a transfer happens on
// every rising edge where ir_valido=1 and ir_pronto=1. ir_valido never drops
// without a transfer except on a redirect, a fault or reset.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   pc               byte address presented to the instruction memory
//   instrucao        word read from memory at pc (same cycle)
//   ir, pc_ir        instruction offered to decode and its address
//   ir_valido        ir/pc_ir valid
//   ir_pronto        decode accepts ir this cycle
//   desvio, alvo     redirect request and its target byte address
//   parar, retomar   halt and resume requests
//   erro             fetch fault flag (sticky until reset)
//   estado           FSM state (debug visibility)
//   contador         number of instructions transferred to decode
module controle_busca
   import mips_pkg::*;
#(
   parameter int                  LARGURA      = LARGURA_PADRAO,
   parameter int                  PALAVRAS_ROM = PALAVRAS_ROM_PADRAO,
   parameter logic [LARGURA-1:0]  PC_INICIAL   = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [LARGURA-1:0] pc,
   input  logic [LARGURA-1:0] instrucao,
   output logic [LARGURA-1:0] ir,
   output logic [LARGURA-1:0] pc_ir,
   output logic               ir_valido,
   input  logic               ir_pronto,
   input  logic               desvio,
   input  logic [LARGURA-1:0] alvo,
   input  logic               parar,
   input  logic               retomar,
   output logic               erro,
   output logic [1:0]         estado,
   output logic [15:0]        contador
);

   estado_t            st;
   logic               transferencia;
   logic [LARGURA-1:0] pc_mais2;
   logic               carry_pc;
   logic               mais2_ok;
   logic               alvo_ok;
   // Set when pc already points past the memory (or at a bad address loaded
   // while halted); the next capture attempt then faults instead of reading.
   logic               pc_fora;

   assign transferencia       = ir_valido & ir_pronto;
   assign {carry_pc, pc_mais2} = {1'b0, pc} + {{LARGURA{1'b0}}, 1'b0} + (LARGURA+1)'(2);
   assign estado              = st;

   verifica_endereco #(
      .LARGURA      (LARGURA),
      .PALAVRAS_ROM (PALAVRAS_ROM)
   ) u_verifica_mais2 (
      .endereco (pc_mais2),
      .valido   (mais2_ok)
   );

   verifica_endereco #(
      .LARGURA      (LARGURA),
      .PALAVRAS_ROM (PALAVRAS_ROM)
   ) u_verifica_alvo (
      .endereco (alvo),
      .valido   (alvo_ok)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= INICIO;
         pc        <= PC_INICIAL;
         ir        <= '0;
         pc_ir     <= '0;
         ir_valido <= 1'b0;
         erro      <= 1'b0;
         contador  <= '0;
         pc_fora   <= 1'b0;
      end else begin
         if (transferencia) begin
            contador <= contador + 16'd1;
         end
         case (st)
            INICIO: begin
               st <= BUSCA;
            end
            BUSCA: begin
               if (desvio) begin
                  // Redirect wins over capture and halt; the pending ir is
                  // dropped. A bad target is kept in pc as the faulting value.
                  pc        <= alvo;
                  ir_valido <= 1'b0;
                  if (!alvo_ok) begin
                     st   <= ERRO;
                     erro <= 1'b1;
                  end else begin
                     pc_fora <= 1'b0;
                  end
               end else if (parar) begin
                  // No new captures; leave once the pending ir has drained.
                  if (!ir_valido || transferencia) begin
                     ir_valido <= 1'b0;
                     st        <= PARADO;
                  end
               end else if (!ir_valido || transferencia) begin
                  if (pc_fora) begin
                     st        <= ERRO;
                     erro      <= 1'b1;
                     ir_valido <= 1'b0;
                  end else begin
                     ir        <= instrucao;
                     pc_ir     <= pc;
                     ir_valido <= 1'b1;
                     pc        <= pc_mais2;
                     pc_fora   <= ~mais2_ok | carry_pc;
                  end
               end
            end
            PARADO: begin
               ir_valido <= 1'b0;
               if (desvio) begin
                  pc      <= alvo;
                  pc_fora <= ~alvo_ok;
               end else if (retomar) begin
                  st <= BUSCA;
               end
            end
            ERRO: begin
               erro      <= 1'b1;
               ir_valido <= 1'b0;
            end
            default: begin
               st <= ERRO;
            end
         endcase
      end
   end

endmodule

// File: doc/controle_busca.md
CONTROLE_BUSCA -- requirements
Module: controle_busca

Interface
REQ-001 Parameter LARGURA, default 16, SHALL be the width of PC, address and instruction.
REQ-002 Parameter PALAVRAS_ROM, default 64, SHALL be the instruction-memory depth in 16-bit words; valid byte addresses are 0..2*PALAVRAS_ROM-2.
REQ-003 Parameter PC_INICIAL, default 16'h0000, SHALL be the PC value after reset.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 pc  out  16  byte address driven to memoria_instrucao (combinational read).
REQ-007 instrucao  in  16  word returned by memoria_instrucao for pc in the same cycle.
REQ-008 ir  out  16  registered instruction offered to decode.
REQ-009 pc_ir  out  16  address from which ir was fetched.
REQ-010 ir_valido  out  1  ir/pc_ir hold a valid instruction.
REQ-011 ir_pronto  in  1  decode accepts ir this cycle.
REQ-012 desvio  in  1  redirect request (branch/jump taken).
REQ-013 alvo  in  16  redirect target byte address, sampled when desvio=1.
REQ-014 parar  in  1  halt request; retomar  in  1  resume request.
REQ-015 erro  out  1  fetch fault (out-of-range or misaligned address); estado  out  2  FSM state encoding.
REQ-016 contador  out  16  number of instructions transferred to decode.

Function
REQ-017 FSM states SHALL be INICIO=0, BUSCA=1, PARADO=2, ERRO=3.
REQ-018 INICIO SHALL last exactly one cycle after reset release, then go to BUSCA; no capture in INICIO.
REQ-019 Transfer occurs on an edge where ir_valido=1 and ir_pronto=1; contador SHALL then increment by 1, wrapping 16'hFFFF->0.
REQ-020 In BUSCA, a capture (ir<=instrucao, pc_ir<=pc, ir_valido<=1, pc<=pc+2) SHALL occur when ir_valido=0 or a transfer happens that cycle; otherwise ir/pc_ir/pc hold (stall).
REQ-021 First ir_valido=1 SHALL appear at the second rising edge after rst_n goes high, with ir=mem[PC_INICIAL].
REQ-022 desvio=1 in BUSCA SHALL take priority over capture: pc<=alvo, ir_valido<=0 next cycle (pending ir discarded, no transfer counted unless ir_pronto=1 that same cycle); capture resumes the following cycle.
REQ-023 desvio with alvo[0]=1 or alvo>2*PALAVRAS_ROM-2 SHALL go to ERRO instead.
REQ-024 Capture when pc+2 would exceed 2*PALAVRAS_ROM-2 SHALL still capture the current word, then go to ERRO on the next capture attempt (no wrap to 0).
REQ-025 parar=1 in BUSCA SHALL stop new captures; FSM enters PARADO once ir_valido=0 (pending ir drained via handshake); parar has lower priority than desvio.
REQ-026 In PARADO, pc holds, ir_valido=0; retomar=1 returns to BUSCA next cycle; desvio in PARADO SHALL load pc and stay PARADO.
REQ-027 In ERRO, erro=1, ir_valido=0, pc holds the faulting value; exit only by reset.

Reset
REQ-028 On rising clk with rst_n=0: state=INICIO, pc=PC_INICIAL, ir=0, pc_ir=0, ir_valido=0, erro=0, contador=0.
REQ-029 Reset asserted mid-operation SHALL override every other input, discarding pending ir in the same edge.

Structure
REQ-030 State encodings and the LARGURA/PALAVRAS_ROM defaults SHALL live in shared package mips_pkg.
REQ-031 Address-check logic (alignment, range) SHALL be one sub-module verifica_endereco, combinational, used for both pc+2 and alvo.
REQ-032 controle_busca SHALL instantiate no memory; memoria_instrucao is connected at the level above.

Verification
REQ-033 Reset release, ir_pronto=1 constant -> ir_valido at edge 2, pc_ir 0,2,4,... one per cycle, contador 1,2,3.
REQ-034 ir_pronto=0 for 3 cycles with ir_valido=1 -> ir, pc_ir, pc, contador unchanged; resume -> no instruction skipped or duplicated.
REQ-035 desvio=1, alvo=16'h0020 while pc=16'h0008 -> next cycle ir_valido=0, pc=16'h0020; following edge pc_ir=16'h0020.
REQ-036 desvio with alvo=16'h0021 and alvo=16'h0080 (PALAVRAS_ROM=64) -> ERRO, erro=1 until rst_n=0.
REQ-037 Sequential fetch to 16'h007E -> mem[63] delivered, then ERRO with pc=16'h0080.
REQ-038 parar=1 with pending ir and ir_pronto=0 -> stays BUSCA; after transfer -> PARADO; retomar=1 -> BUSCA, fetch continues from held pc.
